instr_mem_responder: RTL

- Responder end of the instruction-fetch memory interface driven by the pipeline fetch stage.
- Services level-held fetch requests (address plus activate) from an internal word-addressed instruction memory, with a configurable fixed latency.
- Holds the response stable for as long as the request is held, so a stalled fetch stage never causes a refetch.
- Provides a side load port for program loading and test benches, and flags misaligned or out-of-range fetches.

---
 rtl/instr_mem_responder_if.sv | 28 ++
 rtl/instr_mem_responder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/instr_mem_responder_if.sv
// Instruction-fetch bus between the pipeline fetch stage (master) and the
// instruction memory responder (slave).
interface instr_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] instruction_addr;
    logic                  instruction_fetch_activate;
    logic [DATA_WIDTH-1:0] instruction_data;
    logic                  instruction_fetch_done;
    logic                  instruction_fetch_fault;

    modport master (
        output instruction_addr,
        output instruction_fetch_activate,
        input  instruction_data,
        input  instruction_fetch_done,
        input  instruction_fetch_fault
    );

    modport slave (
        input  instruction_addr,
        input  instruction_fetch_activate,
        output instruction_data,
        output instruction_fetch_done,
        output instruction_fetch_fault
    );
endinterface

// File: rtl/instr_mem_responder.sv
// Fixed-latency instruction memory responder: serves level-held fetch requests,
// holds the response while the request is held, and has a side load port.
module instr_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    instr_mem_responder_if.slave     fetch,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]    load_data
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      counter;
    logic [ADDR_WIDTH-1:0] latched_addr;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  fault_reg;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      latched_idx;
    logic                  same_addr;
    logic                  capture;
    logic                  complete;
    logic                  range_fault;
    logic                  fault_now;
    logic [DATA_WIDTH-1:0] read_word;

    assign latched_idx = latched_addr[IDX_W+1:2];
    assign same_addr   = (fetch.instruction_addr == latched_addr);
    assign capture     = fetch.instruction_fetch_activate && (state == S_IDLE || !same_addr);
    assign complete    = (state == S_WAIT) && fetch.instruction_fetch_activate && same_addr
                         && (counter == '0);

    // With DEPTH a power of two, any set bit above the word index is out of range.
    if (ADDR_WIDTH > IDX_W + 2) begin : g_range
        assign range_fault = |latched_addr[ADDR_WIDTH-1:IDX_W+2];
    end else begin : g_no_range
        assign range_fault = 1'b0;
    end

    assign fault_now = (latched_addr[1:0] != 2'b00) || range_fault;
    // Write-first bypass so a load on the completing edge is returned.
    assign read_word = (load_en && load_addr == latched_idx) ? load_data : mem[latched_idx];

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (fetch.instruction_fetch_activate) next_state = S_WAIT;
            end
            S_WAIT: begin
                if (!fetch.instruction_fetch_activate) next_state = S_IDLE;
                else if (capture)                      next_state = S_WAIT;
                else if (counter == '0)                next_state = S_READY;
            end
            S_READY: begin
                if (!fetch.instruction_fetch_activate) next_state = S_IDLE;
                else if (capture)                      next_state = S_WAIT;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter      <= '0;
            latched_addr <= '0;
            data_reg     <= '0;
            fault_reg    <= 1'b0;
        end else begin
            if (capture) begin
                latched_addr <= fetch.instruction_addr;
                counter      <= CNT_W'(LATENCY - 1);
            end else if (state == S_WAIT && counter != '0) begin
                counter <= counter - 1'b1;
            end

            if (complete) begin
                fault_reg <= fault_now;
                data_reg  <= fault_now ? '0 : read_word;
            end else if (state == S_READY && !fault_reg && load_en && load_addr == latched_idx) begin
                data_reg <= load_data;
            end
        end
    end

    // Done is qualified combinationally so a new address never sees the old word.
    always_comb begin
        fetch.instruction_fetch_done  = 1'b0;
        fetch.instruction_data        = '0;
        fetch.instruction_fetch_fault = 1'b0;
        if (state == S_READY && fetch.instruction_fetch_activate && same_addr) begin
            fetch.instruction_fetch_done  = 1'b1;
            fetch.instruction_data        = data_reg;
            fetch.instruction_fetch_fault = fault_reg;
        end
    end
endmodule
